hacd_reg_initiator: RTL and testbench
=====================================

HACD_REG_INITIATOR -- requirements
Module: hacd_reg_initiator

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4, meaning command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256, meaning cycles waiting for resp.ready before abort (≥2).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-005 SHALL have port cmd_valid_i  input  1  command offered.
REQ-006 SHALL have port cmd_ready_o  output  1  FIFO can accept.
REQ-007 SHALL have port cmd_write_i  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr_i  input  32  register byte address.
REQ-009 SHALL have port cmd_wdata_i  input  32  write data.
REQ-010 SHALL have port cmd_wstrb_i  input  4  byte strobes.
REQ-011 SHALL have port req_o  output  hacd_pkg::reg_intf_req_a32_d32  register bus request (addr, write, wdata, wstrb, valid).
REQ-012 SHALL have port resp_i  input  hacd_pkg::reg_intf_resp_d32  register bus response (rdata, error, ready).
REQ-013 SHALL have port rsp_valid_o  output  1  completion available.
REQ-014 SHALL have port rsp_ready_i  input  1  consumer accepts completion.
REQ-015 SHALL have port rsp_rdata_o  output  32  read data (0 for writes).
REQ-016 SHALL have port rsp_error_o  output  1  resp.error sampled at completion.
REQ-017 SHALL have port rsp_timeout_o  output  1  transaction aborted by timeout.
REQ-018 SHALL have port busy_o  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-019 SHALL accept a command when cmd_valid_i && cmd_ready_o; cmd_ready_o = FIFO not full, registered-free combinational from count.
REQ-020 SHALL implement FSM IDLE, ISSUE, RESP: IDLE->ISSUE when FIFO non-empty (pop head); ISSUE->RESP on req_o.valid && resp_i.ready or timeout; RESP->IDLE (or ->ISSUE if FIFO non-empty) on rsp_valid_o && rsp_ready_i.
REQ-021 SHALL drive req_o.valid=1 only in ISSUE; addr/write/wdata/wstrb SHALL be registered and stable throughout ISSUE.
REQ-022 SHALL complete a bus beat in the cycle valid && resp_i.ready; earliest handshake is the first ISSUE cycle, i.e. cmd accept to req_o.valid = 2 cycles from empty.
REQ-023 SHALL capture resp_i.rdata (reads only) and resp_i.error in the handshake cycle; writes report rdata=0.
REQ-024 SHALL count ISSUE cycles in a counter of $clog2(TIMEOUT_CYC+1) bits, cleared on ISSUE entry; at count==TIMEOUT_CYC-1 without ready, SHALL drop valid next cycle, set rsp_timeout_o=1, rsp_error_o=1, rdata=0.
REQ-025 SHALL hold rsp_* stable while rsp_valid_o && !rsp_ready_i; no new bus request issued until completion consumed (one outstanding).
REQ-026 Simultaneous FIFO push and pop SHALL keep count unchanged; push when full SHALL be ignored (ready=0); pointers wrap modulo CMD_DEPTH.
REQ-027 SHALL ignore resp_i.ready outside ISSUE.
REQ-028 Commands SHALL complete strictly in acceptance order.

Reset
REQ-029 On rst_i SHALL go IDLE, FIFO empty, counter 0; outputs: cmd_ready_o=1 after reset release, req_o all zero, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, rsp_timeout_o=0, busy_o=0.
REQ-030 Reset asserted mid-ISSUE SHALL drop req_o.valid asynchronously; in-flight and queued commands discarded, no completion emitted.

Structure
REQ-031 reg_intf_req_a32_d32/reg_intf_resp_d32 SHALL come from hacd_pkg; FSM state enum and command struct (write, addr, wdata, wstrb) SHALL be added to hacd_pkg.
REQ-032 Command FIFO SHALL be one sub-module, hacd_reg_cmd_fifo, parameterised by depth and struct width.

Verification
REQ-033 Write 0x10 data 0xDEADBEEF wstrb 0xF, responder ready same cycle -> req_o.valid 2 cycles after accept for 1 cycle, completion rdata=0 error=0.
REQ-034 Read 0x20, responder ready after 5 cycles with rdata 0x12345678 -> valid held 6 cycles, addr stable, rsp_rdata_o=0x12345678.
REQ-035 Push 5 commands with DEPTH=4, rsp_ready_i=0 -> cmd_ready_o=0 after 4th queued plus 1 in flight; order preserved on drain.
REQ-036 Responder never ready, TIMEOUT_CYC=8 -> valid high exactly 8 cycles, completion timeout=1 error=1 rdata=0.
REQ-037 Responder returns error=1 on write -> rsp_error_o=1, timeout=0.
REQ-038 rst_i pulse during ISSUE with 2 queued -> req_o.valid=0 immediately, busy_o=0, no rsp_valid_o afterward.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared types for the HACD register-bus initiator: bus structs, FSM state, queued command.
package hacd_pkg;

  // Register bus request, 32-bit address and data.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  // Register bus response, 32-bit data.
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } init_state_e;

  // One queued command as it sits in the command FIFO.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  localparam int unsigned CmdWidth = $bits(cmd_t);

  // Build an asserted bus request from a queued command.
  function automatic reg_intf_req_a32_d32 cmd_to_req(cmd_t c);
    reg_intf_req_a32_d32 r;
    r.addr  = c.addr;
    r.write = c.write;
    r.wdata = c.wdata;
    r.wstrb = c.wstrb;
    r.valid = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hacd_reg_cmd_fifo.sv
// Command FIFO: power-of-two depth, head visible combinationally, overflow pushes dropped.
module hacd_reg_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only slots below count are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/hacd_reg_initiator.sv
// Register-bus initiator: queues commands, issues one bus beat at a time, reports completions.
module hacd_reg_initiator
  import hacd_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [3:0]          cmd_wstrb_i,
  output reg_intf_req_a32_d32 req_o,
  input  reg_intf_resp_d32    resp_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_error_o,
  output logic                rsp_timeout_o,
  output logic                busy_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  init_state_e         state_q;
  reg_intf_req_a32_d32 req_q;
  logic [TmoW-1:0]     tmo_cnt_q;
  logic                rsp_valid_q, rsp_error_q, rsp_timeout_q;
  logic [31:0]         rsp_rdata_q;

  cmd_t                cmd_in, cmd_head;
  logic [CmdWidth-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, fifo_pop;

  assign cmd_in = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i,
                    wstrb: cmd_wstrb_i};
  assign cmd_head = fifo_rdata;

  hacd_reg_cmd_fifo #(
    .Depth (CMD_DEPTH),
    .Width (CmdWidth)
  ) u_cmd_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (cmd_valid_i),
    .wdata (cmd_in),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  // Head leaves the FIFO when a new beat starts: from idle, or right as a completion is consumed.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == StIdle) || ((state_q == StResp) && rsp_ready_i));

  // Transaction FSM; all bus and completion outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      req_q         <= '0;
      tmo_cnt_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            req_q     <= cmd_to_req(cmd_head);
            tmo_cnt_q <= '0;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (resp_i.ready) begin
            req_q.valid   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= req_q.write ? 32'h0 : resp_i.rdata;
            rsp_error_q   <= resp_i.error;
            rsp_timeout_q <= 1'b0;
            state_q       <= StResp;
          end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
            req_q.valid   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 32'h0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            if (!fifo_empty) begin
              req_q     <= cmd_to_req(cmd_head);
              tmo_cnt_q <= '0;
              state_q   <= StIssue;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o   = !fifo_full;
  assign req_o         = req_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_hacd_reg_initiator.sv
// Directed bench for hacd_reg_initiator with a bus responder model and completion scoreboard.
module tb_hacd_reg_initiator;
  import hacd_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } exp_rsp_t;

  logic                clk;
  logic                rst;
  logic                cmd_valid, cmd_ready, cmd_write;
  logic [31:0]         cmd_addr, cmd_wdata;
  logic [3:0]          cmd_wstrb;
  reg_intf_req_a32_d32 req;
  reg_intf_resp_d32    resp;
  logic                rsp_valid, rsp_ready, rsp_error, rsp_timeout, busy;
  logic [31:0]         rsp_rdata;

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;

  // Responder knobs.
  int   resp_delay = 0;
  logic resp_never = 1'b0;
  logic resp_err   = 1'b0;
  int   wait_cnt;

  cmd_t     exp_req[$];
  exp_rsp_t exp_rsp[$];

  hacd_reg_initiator #(
    .CMD_DEPTH   (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_wstrb_i   (cmd_wstrb),
    .req_o         (req),
    .resp_i        (resp),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_error_o   (rsp_error),
    .rsp_timeout_o (rsp_timeout),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rmodel(logic [31:0] addr);
    if (addr == 32'h20) return 32'h1234_5678;
    return {addr[15:0], 16'hC0DE};
  endfunction

  // Cycles the current request has been valid; ready follows after resp_delay of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!req.valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Ready is also high while no request is pending, which the DUT must ignore.
  always_comb begin
    resp.rdata = rmodel(req.addr);
    resp.error = resp_err;
    if (resp_never) resp.ready = 1'b0;
    else if (req.valid) resp.ready = (wait_cnt >= resp_delay);
    else resp.ready = 1'b1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus handshakes and completions are checked mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (req.valid && resp.ready) begin
        if (exp_req.size() == 0) begin
          check("req_unexpected", 1, 0);
        end else begin
          cmd_t e;
          e = exp_req.pop_front();
          check("req_addr", req.addr, e.addr);
          check("req_write", req.write, e.write);
          check("req_wdata", req.wdata, e.wdata);
          check("req_wstrb", req.wstrb, e.wstrb);
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_done++;
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          exp_rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_error", rsp_error, e.error);
          check("rsp_timeout", rsp_timeout, e.timeout);
        end
      end
    end
  end

  task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic err, input logic to,
                          input bit track);
    int n = 0;
    exp_rsp_t r;
    cmd_t c;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = strb;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    check("push_accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    if (track) begin
      c = '{write: wr, addr: addr, wdata: wdata, wstrb: strb};
      r.rdata   = (wr || to) ? 32'h0 : rmodel(addr);
      r.error   = err || to;
      r.timeout = to;
      exp_rsp.push_back(r);
      if (!to) exp_req.push_back(c);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic count_valid(input string tag, input logic [31:0] addr, output int vc);
    vc = 0;
    while (req.valid && vc < 50) begin
      check(tag, req.addr, addr);
      vc++;
      step();
    end
  endtask

  initial begin
    int vc;
    int seen;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst_req", req, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_req", req, 0);
    check("rel_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout}, 0);
    check("rel_busy", busy, 0);

    // Write with immediate ready: valid two cycles after accept, for one cycle.
    push_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b1);
    check("wr_lat_c1", req.valid, 0);
    check("wr_busy", busy, 1);
    step();
    check("wr_lat_c2", req.valid, 1);
    check("wr_addr", req.addr, 32'h10);
    step();
    check("wr_valid_drop", req.valid, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    step();
    check("wr_rsp_gone", rsp_valid, 0);
    wait_idle("wr_idle");

    // Read with ready after 5 waiting cycles.
    resp_delay = 5;
    push_cmd(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    step();
    count_valid("rd_addr_stable", 32'h20, vc);
    check("rd_valid_cycles", vc, 6);
    wait_idle("rd_idle");

    // Responder never ready: timeout after exactly 8 valid cycles.
    resp_never = 1'b1;
    push_cmd(1'b1, 32'h30, 32'h5555_AAAA, 4'h3, 1'b0, 1'b1, 1'b1);
    step();
    count_valid("to_addr_stable", 32'h30, vc);
    check("to_valid_cycles", vc, 8);
    wait_idle("to_idle");
    resp_never = 1'b0;

    // Bus error on a write.
    resp_delay = 0;
    resp_err   = 1'b1;
    push_cmd(1'b1, 32'h40, 32'h0BAD_F00D, 4'h1, 1'b1, 1'b0, 1'b1);
    wait_idle("err_idle");
    resp_err = 1'b0;

    // Fill: one in flight held in completion, four queued, then back-pressure.
    resp_delay = 1;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(i[0], 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1), 1'b0, 1'b0,
               1'b1);
    end
    check("full_cmd_ready", cmd_ready, 0);
    check("full_one_outstanding", req.valid, 0);
    check("full_rsp_valid", rsp_valid, 1);
    cmd_valid = 1'b1;
    cmd_addr  = 32'hBAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_hold_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("drain_idle");
    check("drain_sb_empty", exp_rsp.size(), 0);

    // Reset mid-issue with two commands queued.
    resp_never = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_cmd(1'b1, 32'h200 + 32'(i * 4), 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    end
    check("pre_rst_valid", req.valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", req.valid, 0);
    check("async_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    resp_never = 1'b0;
    resp_delay = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid || req.valid) seen++;
      step();
    end
    check("post_rst_quiet", seen, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    // Recovery read.
    push_cmd(1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    wait_idle("recov_idle");

    check("final_rsp_sb", exp_rsp.size(), 0);
    check("final_req_sb", exp_req.size(), 0);
    check("final_completions", n_done, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
